// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//
// Sits below one systolic-array column and accumulates the partial sums that
// leave the bottom MAC PE. Each tile consists of num_pass K-tile passes of
// len partial sums each. Pass 0 overwrites the register buffer; later passes
// add into it. After the final pass the buffer is drained over a valid/ready
// stream, one entry per handshake, followed by a one-cycle done pulse.
//
// Optional feature macro: PSUM_RELU_EN
//   defined   -> drained values are clamped at zero (ReLU); buffer unaffected
//   undefined -> drained values pass through unmodified (signed)
//
// Ports
//   clk              clock
//   rst              synchronous, active-high reset
//   start_in         start a tile (sampled only in IDLE)
//   len_in           entries per pass, legal 1..DEPTH
//   num_pass_in      passes per tile, 0 treated as 1
//   MAC_valid_in     partial sum valid from the column's bottom PE
//   MAC_data_in      signed partial sum
//   ofmap_valid_out  drain data valid
//   ofmap_ready_in   downstream ready
//   ofmap_data_out   drained accumulated value (0 outside DRAIN)
//   busy_out         high whenever the block is not IDLE
//   done_out         one-cycle pulse after the last drain handshake
//   overrun_err_out  sticky: partial sum outside ACCUM, or illegal len_in
// -----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int OFMAP_BITWIDTH = 32,
    parameter int ACC_BITWIDTH   = 32,
    parameter int DEPTH          = 16,
    parameter int PASS_BITWIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic [$clog2(DEPTH):0]        len_in,
    input  logic [PASS_BITWIDTH-1:0]      num_pass_in,
    input  logic                          MAC_valid_in,
    input  logic [OFMAP_BITWIDTH-1:0]     MAC_data_in,
    output logic                          ofmap_valid_out,
    input  logic                          ofmap_ready_in,
    output logic [ACC_BITWIDTH-1:0]       ofmap_data_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          overrun_err_out
);

    localparam int LEN_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Tile configuration, stored as "last index" values so the end-of-pass
    // and end-of-tile tests are plain equality compares.
    logic [IDX_W-1:0]          len_last_q;
    logic [PASS_BITWIDTH-1:0]  pass_last_q;

    logic [IDX_W-1:0]          wr_idx_q;
    logic [IDX_W-1:0]          rd_idx_q;
    logic [PASS_BITWIDTH-1:0]  pass_q;
    logic                      done_q;
    logic                      err_q;

    logic signed [ACC_BITWIDTH-1:0] acc_buf [DEPTH];

    logic                           start_ok;
    logic                           mac_accept;
    logic                           drain_hs;
    logic                           last_wr;
    logic                           last_pass;
    logic                           last_rd;
    logic signed [OFMAP_BITWIDTH-1:0] mac_s;
    logic signed [ACC_BITWIDTH-1:0] mac_ext;
    logic signed [ACC_BITWIDTH-1:0] rd_val;

    assign start_ok   = (len_in != '0) && (len_in <= LEN_W'(DEPTH));
    assign mac_accept = (state_q == ACCUM) && MAC_valid_in;
    assign drain_hs   = (state_q == DRAIN) && ofmap_ready_in;
    assign last_wr    = (wr_idx_q == len_last_q);
    assign last_pass  = (pass_q == pass_last_q);
    assign last_rd    = (rd_idx_q == len_last_q);

    // A size cast of a signed operand sign-extends to the accumulator width.
    assign mac_s   = MAC_data_in;
    assign mac_ext = ACC_BITWIDTH'(mac_s);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_in && start_ok) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (mac_accept && last_wr && last_pass) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_hs && last_rd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, buffer, status flags
    // ------------------------------------------------------------------
    // NOTE: the buffer is explicitly cleared on reset because reset must
    // leave every entry at zero; this costs a reset on each storage flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_last_q  <= '0;
            pass_last_q <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pass_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                acc_buf[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            if ((state_q == IDLE) && start_in) begin
                if (start_ok) begin
                    len_last_q  <= IDX_W'(len_in - LEN_W'(1));
                    pass_last_q <= (num_pass_in == '0) ? '0
                                                       : num_pass_in - PASS_BITWIDTH'(1);
                    wr_idx_q    <= '0;
                    pass_q      <= '0;
                    err_q       <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (mac_accept) begin
                if (pass_q == '0) begin
                    acc_buf[wr_idx_q] <= mac_ext;
                end else begin
                    // Two's-complement wrap: the carry out is intentionally dropped.
                    acc_buf[wr_idx_q] <= acc_buf[wr_idx_q] + mac_ext;
                end
                if (last_wr) begin
                    wr_idx_q <= '0;
                    pass_q   <= pass_q + PASS_BITWIDTH'(1);
                    if (last_pass) begin
                        rd_idx_q <= '0;
                    end
                end else begin
                    wr_idx_q <= wr_idx_q + IDX_W'(1);
                end
            end

            // Placed after the start-clear so a stray partial sum in the same
            // cycle as an accepted start is still flagged.
            if (MAC_valid_in && (state_q != ACCUM)) begin
                err_q <= 1'b1;
            end

            if (drain_hs) begin
                if (last_rd) begin
                    rd_idx_q <= '0;
                    done_q   <= 1'b1;
                end else begin
                    rd_idx_q <= rd_idx_q + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_val = acc_buf[rd_idx_q];

    always_comb begin
        ofmap_data_out = '0;
        if (state_q == DRAIN) begin
`ifdef PSUM_RELU_EN
            ofmap_data_out = rd_val[ACC_BITWIDTH-1] ? '0 : rd_val;
`else
            ofmap_data_out = rd_val;
`endif
        end
    end

    assign ofmap_valid_out = (state_q == DRAIN);
    assign busy_out        = (state_q != IDLE);
    assign done_out        = done_q;
    assign overrun_err_out = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
//
// Directed self-checking bench for psum_accumulator with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same
// point, well away from the next active edge. Expected values are hand-derived
// constants; the ReLU build flips the expectations for negative results.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int OFMAP_BITWIDTH = 32;
    localparam int ACC_BITWIDTH   = 32;
    localparam int DEPTH          = 16;
    localparam int PASS_BITWIDTH  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start_in;
    logic [$clog2(DEPTH):0]    len_in;
    logic [PASS_BITWIDTH-1:0]  num_pass_in;
    logic                      MAC_valid_in;
    logic [OFMAP_BITWIDTH-1:0] MAC_data_in;
    logic                      ofmap_valid_out;
    logic                      ofmap_ready_in;
    logic [ACC_BITWIDTH-1:0]   ofmap_data_out;
    logic                      busy_out;
    logic                      done_out;
    logic                      overrun_err_out;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(
        .OFMAP_BITWIDTH (OFMAP_BITWIDTH),
        .ACC_BITWIDTH   (ACC_BITWIDTH),
        .DEPTH          (DEPTH),
        .PASS_BITWIDTH  (PASS_BITWIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .len_in          (len_in),
        .num_pass_in     (num_pass_in),
        .MAC_valid_in    (MAC_valid_in),
        .MAC_data_in     (MAC_data_in),
        .ofmap_valid_out (ofmap_valid_out),
        .ofmap_ready_in  (ofmap_ready_in),
        .ofmap_data_out  (ofmap_data_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .overrun_err_out (overrun_err_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int len, input int np);
        start_in    = 1'b1;
        len_in      = 5'(len);
        num_pass_in = 8'(np);
        step();
        start_in    = 1'b0;
    endtask

    task automatic push(input int d);
        MAC_valid_in = 1'b1;
        MAC_data_in  = 32'(d);
        step();
        MAC_valid_in = 1'b0;
        MAC_data_in  = '0;
    endtask

    // 1: reset values, then a reset in the middle of ACCUM aborts the tile.
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (ofmap_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ofmap_valid_out); end
        checks++; if (ofmap_data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ofmap_data_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_out); end
        checks++; if (overrun_err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", overrun_err_out); end
        rst = 1'b0;

        start_tile(4, 1);
        push(10);
        push(20);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL midtile_busy: got %b want 1", busy_out); end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_out); end
        checks++; if (ofmap_valid_out !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", ofmap_valid_out); end
        checks++; if (overrun_err_out !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", overrun_err_out); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL abort_no_done[%0d]: got done=%b busy=%b want 0 0", i, done_out, busy_out); end
            step();
        end
    endtask

    // 2: single pass, full-rate drain, done pulse.
    task automatic test_single_pass();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'd1; exp_v[1] = 32'd2; exp_v[2] = 32'd3; exp_v[3] = 32'd4;
        start_tile(4, 1);
        for (int i = 1; i <= 4; i++) push(i);
        ofmap_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ofmap_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", i, ofmap_valid_out); end
            checks++; if (ofmap_data_out !== exp_v[i]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, ofmap_data_out, exp_v[i]); end
            step();
        end
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done_out); end
        checks++; if (busy_out !== 1'b0 || ofmap_valid_out !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy_out, ofmap_valid_out); end
        checks++; if (ofmap_data_out !== 32'h0) begin errors++; $display("FAIL single_data_idle: got %h want 0", ofmap_data_out); end
        step();
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done_out); end
    endtask

    // 3: three passes with gaps, negative sums.
    task automatic test_multi_pass();
        logic [31:0] exp_v [2];
`ifdef PSUM_RELU_EN
        exp_v[0] = 32'h0; exp_v[1] = 32'h0;
`else
        exp_v[0] = 32'hFFFF_FFFB; exp_v[1] = 32'hFFFF_FFFC;
`endif
        ofmap_ready_in = 1'b1;
        start_tile(2, 3);
        push(5);
        push(-7);
        step();
        push(10);
        push(2);
        push(-20);
        step();
        step();
        checks++; if (ofmap_valid_out !== 1'b0) begin errors++; $display("FAIL multi_early_valid: got %b want 0", ofmap_valid_out); end
        push(1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (ofmap_valid_out !== 1'b1) begin errors++; $display("FAIL multi_valid[%0d]: got %b want 1", i, ofmap_valid_out); end
            checks++; if (ofmap_data_out !== exp_v[i]) begin errors++; $display("FAIL multi_data[%0d]: got %h want %h", i, ofmap_data_out, exp_v[i]); end
            step();
        end
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL multi_done: got %b want 1", done_out); end
    endtask

    // 4: back-pressure keeps data stable and order intact.
    task automatic test_backpressure();
        logic        ready_pat [5];
        logic [31:0] exp_v [5];
        ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1; ready_pat[4] = 1'b1;
        exp_v[0] = 32'd7; exp_v[1] = 32'd8; exp_v[2] = 32'd8; exp_v[3] = 32'd8; exp_v[4] = 32'd9;
        start_tile(3, 1);
        push(7);
        push(8);
        push(9);
        for (int i = 0; i < 5; i++) begin
            ofmap_ready_in = ready_pat[i];
            checks++; if (ofmap_valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, ofmap_valid_out); end
            checks++; if (ofmap_data_out !== exp_v[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, ofmap_data_out, exp_v[i]); end
            checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL bp_early_done[%0d]: got %b want 0", i, done_out); end
            step();
        end
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done_out); end
        ofmap_ready_in = 1'b1;
    endtask

    // 5: partial sum arriving during DRAIN is dropped and flagged.
    task automatic test_overrun();
        start_tile(2, 1);
        push(3);
        push(4);
        ofmap_ready_in = 1'b0;
        checks++; if (overrun_err_out !== 1'b0) begin errors++; $display("FAIL ovr_err_before: got %b want 0", overrun_err_out); end
        push(99);
        checks++; if (overrun_err_out !== 1'b1) begin errors++; $display("FAIL ovr_err_set: got %b want 1", overrun_err_out); end
        checks++; if (ofmap_data_out !== 32'd3) begin errors++; $display("FAIL ovr_data0_stall: got %h want 3", ofmap_data_out); end
        ofmap_ready_in = 1'b1;
        checks++; if (ofmap_data_out !== 32'd3) begin errors++; $display("FAIL ovr_data0: got %h want 3", ofmap_data_out); end
        step();
        checks++; if (ofmap_data_out !== 32'd4) begin errors++; $display("FAIL ovr_data1: got %h want 4", ofmap_data_out); end
        step();
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL ovr_done: got %b want 1", done_out); end
        checks++; if (overrun_err_out !== 1'b1) begin errors++; $display("FAIL ovr_err_sticky: got %b want 1", overrun_err_out); end
    endtask

    // 6: accumulator wrap, num_pass=0, illegal len values.
    task automatic test_wrap_and_len();
        logic [31:0] exp_wrap;
`ifdef PSUM_RELU_EN
        exp_wrap = 32'h0;
`else
        exp_wrap = 32'h8000_0000;
`endif
        ofmap_ready_in = 1'b1;
        start_tile(1, 2);
        checks++; if (overrun_err_out !== 1'b0) begin errors++; $display("FAIL wrap_err_cleared: got %b want 0", overrun_err_out); end
        push(32'h7FFF_FFFF);
        checks++; if (busy_out !== 1'b1 || ofmap_valid_out !== 1'b0) begin errors++; $display("FAIL wrap_pass0: got busy=%b valid=%b want 1 0", busy_out, ofmap_valid_out); end
        push(1);
        checks++; if (ofmap_valid_out !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", ofmap_valid_out); end
        checks++; if (ofmap_data_out !== exp_wrap) begin errors++; $display("FAIL wrap_data: got %h want %h", ofmap_data_out, exp_wrap); end
        step();
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done_out); end

        start_tile(0, 1);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy_out); end
        checks++; if (overrun_err_out !== 1'b1) begin errors++; $display("FAIL len0_err: got %b want 1", overrun_err_out); end

        start_tile(1, 0);
        checks++; if (busy_out !== 1'b1 || overrun_err_out !== 1'b0) begin errors++; $display("FAIL np0_start: got busy=%b err=%b want 1 0", busy_out, overrun_err_out); end
        push(42);
        checks++; if (ofmap_valid_out !== 1'b1 || ofmap_data_out !== 32'd42) begin errors++; $display("FAIL np0_data: got valid=%b data=%h want 1 2a", ofmap_valid_out, ofmap_data_out); end
        step();
        checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL np0_done: got %b want 1", done_out); end

        start_tile(17, 1);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL len17_busy: got %b want 0", busy_out); end
        checks++; if (overrun_err_out !== 1'b1) begin errors++; $display("FAIL len17_err: got %b want 1", overrun_err_out); end
    endtask

    initial begin
        rst            = 1'b1;
        start_in       = 1'b0;
        len_in         = '0;
        num_pass_in    = '0;
        MAC_valid_in   = 1'b0;
        MAC_data_in    = '0;
        ofmap_ready_in = 1'b0;

        test_reset();
        test_single_pass();
        test_multi_pass();
        test_backpressure();
        test_overrun();
        test_wrap_and_len();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
